dmem_responder: RTL and testbench

Memory-side responder for the load/store unit's data port: a single-port, word-organised data RAM behind a valid/ready request channel and a one-cycle response pulse. It executes byte, half-word and word loads and stores at any byte alignment. Accesses that cross a word boundary are split into two sequential word beats. Completion is returned with load data already shifted, sign- or zero-extended. It sits between the LSU and the data RAM for the 0x0000_0000–0x0000_7FFF region.

---
 rtl/dmem_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the load/store unit data port. A single-port,
// word-organised data RAM sits behind a valid/ready request channel. Completion
// is reported with a one-cycle response pulse. Byte, half-word and word loads
// and stores are supported at any byte alignment. An access that crosses a
// word boundary is split into two sequential word beats. Load data is returned
// right-justified and sign- or zero-extended.
//
// Ports
//   i_clk          clock; all state updates on the rising edge
//   i_reset        synchronous, active-high reset (the RAM array is kept)
//   i_req_valid    request present
//   o_req_ready    high only while idle
//   i_req_addr     byte address
//   i_req_wdata    store data, right-justified
//   i_req_size     00 byte, 01 half, 10/11 word
//   i_req_wren     1 store, 0 load
//   i_req_signed   sign-extend a loaded byte/half
//   o_rsp_valid    one-cycle completion pulse
//   o_rsp_rdata    load result; 0 for stores, errors and outside the pulse
//   o_rsp_err      range error, qualified by o_rsp_valid
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH_WORDS = 8192,
  parameter logic [31:0] ADDR_LIMIT  = 32'h0000_7FFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_wren,
  input  logic        i_req_signed,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  // Latched request. Only the address bits that index the RAM are kept,
  // because the range check has already rejected anything beyond it.
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          wren_q;
  logic          signed_q;
  logic          err_q;

  // ---------------------------------------------------------------------------
  // Range check on the incoming request.
  // The last byte address is formed in 33 bits so that a request near
  // 0xFFFF_FFFF cannot wrap around into the legal window.
  // ---------------------------------------------------------------------------
  logic [2:0]  req_nbytes;
  logic [32:0] req_last;
  logic        req_range_err;
  logic        accept;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (no latch).
    req_nbytes = 3'd4;
    case (i_req_size)
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
  end

  assign req_last      = {1'b0, i_req_addr} + {30'd0, req_nbytes} - 33'd1;
  assign req_range_err = (req_last > {1'b0, ADDR_LIMIT});
  assign accept        = (state_q == S_IDLE) && i_req_valid;

  // ---------------------------------------------------------------------------
  // Beat geometry for the latched request.
  // The datum is placed into an 8-byte lane window starting at the byte
  // offset: lanes 0..3 belong to word addr[31:2], lanes 4..7 to the next word.
  // Any lane set in the upper half means the access needs a second beat.
  // ---------------------------------------------------------------------------
  logic [1:0]    offset;
  logic [3:0]    size_mask;
  logic [7:0]    lane_mask;
  logic [55:0]   lane_data;
  logic          split;
  logic [AW-1:0] word0;
  logic [AW-1:0] word1;

  assign offset = addr_q[1:0];

  always_comb begin
    size_mask = 4'b1111;
    case (size_q)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign lane_mask = {4'b0000, size_mask} << offset;
  assign lane_data = {24'd0, wdata_q} << {offset, 3'b000};
  assign split     = |lane_mask[7:4];
  assign word0     = addr_q[AW+1:2];
  assign word1     = word0 + AW'(1);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          state_d = req_range_err ? S_RESP : S_BEAT0;
        end
      end
      S_BEAT0: state_d = split ? S_BEAT1 : S_RESP;
      S_BEAT1: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    if (i_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      wren_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= i_req_addr[AW+1:0];
        wdata_q  <= i_req_wdata;
        size_q   <= i_req_size;
        wren_q   <= i_req_wren;
        signed_q <= i_req_signed;
        err_q    <= req_range_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port. One word is addressed per beat. A store writes only the byte
  // lanes the datum covers in that word. A reset arriving during a beat
  // suppresses that beat's write, so an abandoned split store leaves the
  // second word untouched.
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [DEPTH_WORDS];
  logic          in_beat;
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   beat0_q;
  logic [23:0]   beat1_q;   // the second beat never supplies its top byte

  assign in_beat   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
  assign mem_we    = in_beat && wren_q && !i_reset;
  assign mem_idx   = (state_q == S_BEAT1) ? word1 : word0;
  assign mem_be    = (state_q == S_BEAT1) ? lane_mask[7:4] : lane_mask[3:0];
  assign mem_wdata = (state_q == S_BEAT1) ? {8'd0, lane_data[55:32]}
                                          : lane_data[31:0];

  // NOTE: the RAM array and its read registers have no reset; memory contents
  // must survive i_reset, and a reset on a RAM would prevent block-RAM mapping.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
    if (state_q == S_BEAT0) begin
      beat0_q <= mem[mem_idx];
    end
    if (state_q == S_BEAT1) begin
      beat1_q <= mem[mem_idx][23:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Load assembly: concatenate the two beats, pick the 32 bits that start at
  // the byte offset, then extend according to size. For a non-split access
  // the stale second beat only feeds bytes that the size mask discards.
  // ---------------------------------------------------------------------------
  logic [55:0] beats;
  logic [31:0] aligned;
  logic [31:0] load_data;

  assign beats   = {beat1_q, beat0_q};
  assign aligned = beats[{offset, 3'b000} +: 32];

  always_comb begin
    load_data = aligned;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & aligned[7]}},  aligned[7:0]};
      2'b01:   load_data = {{16{signed_q & aligned[15]}}, aligned[15:0]};
      default: load_data = aligned;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_err   = (state_q == S_RESP) && err_q;
  assign o_rsp_rdata = ((state_q == S_RESP) && !wren_q && !err_q) ? load_data
                                                                  : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder: directed vector table, a reset
// abandoning a split store, then random traffic against a byte-array model.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic        i_clk;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [1:0]  i_req_size;
  logic        i_req_wren;
  logic        i_req_signed;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  dmem_responder dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_size   (i_req_size),
    .i_req_wren   (i_req_wren),
    .i_req_signed (i_req_signed),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: the RAM seen as a flat little-endian byte array.
  logic [7:0] mem_m [32768];

  typedef struct {
    string       name;
    bit          wren;
    bit          sgn;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input bit wren, input bit sgn,
                              input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input bit exp_err,
                              input int exp_lat);
    vec_t v;
    v.name = name; v.wren = wren; v.sgn = sgn; v.size = size; v.addr = addr;
    v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Model of one request: range rule, crossing rule, byte-wise little-endian
  // access and extension, straight from the behavioural description.
  task automatic model_op(input bit wren, input bit sgn, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output bit err,
                          output int lat);
    int n;
    longint last;
    longint v;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    last = longint'(addr) + n - 1;
    rd   = 32'd0;
    err  = 1'b0;
    if (last > 32'h7FFF) begin
      err = 1'b1;
      lat = 1;
    end else begin
      lat = ((int'(addr % 4) + n) > 4) ? 3 : 2;
      if (wren) begin
        for (int k = 0; k < n; k++) mem_m[int'(addr) + k] = wdata[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(mem_m[int'(addr) + k]) << (8*k));
        if (sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        rd = 32'(v);
      end
    end
  endtask

  // Issue one request starting from an idle cycle (#1 after a rising edge).
  // Valid stays high with garbage fields while busy to show they are ignored.
  task automatic do_req(input bit wren, input bit sgn, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err,
                        output int lat, output bit quiet, output bit idle_after);
    quiet = 1'b1;
    lat   = 99;
    rd    = 32'hxxxx_xxxx;
    err   = 1'bx;
    i_req_valid  = 1'b1;
    i_req_wren   = wren;
    i_req_signed = sgn;
    i_req_size   = size;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    @(posedge i_clk); #1;
    for (int c = 1; c <= 8; c++) begin
      if (o_rsp_valid) begin
        rd  = o_rsp_rdata;
        err = o_rsp_err;
        lat = c;
        if (o_req_ready) quiet = 1'b0;
        break;
      end
      if (o_req_ready || o_rsp_rdata != 32'd0 || o_rsp_err) quiet = 1'b0;
      i_req_addr   = $urandom;
      i_req_wdata  = $urandom;
      i_req_size   = 2'($urandom_range(0, 3));
      i_req_wren   = 1'($urandom_range(0, 1));
      i_req_signed = 1'($urandom_range(0, 1));
      @(posedge i_clk); #1;
    end
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    idle_after = o_req_ready && !o_rsp_valid && (o_rsp_rdata == 32'd0) && !o_rsp_err;
  endtask

  task automatic run_and_check(input string name, input bit wren, input bit sgn,
                               input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               input logic [31:0] exp_rd, input bit exp_err,
                               input int exp_lat);
    logic [31:0] rd;
    logic        err;
    int          lat;
    bit          quiet;
    bit          idle_after;
    do_req(wren, sgn, size, addr, wdata, rd, err, lat, quiet, idle_after);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " rdata"}, rd, exp_rd);
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " busy_quiet"}, 32'(quiet), 32'd1);
    check({name, " idle_after"}, 32'(idle_after), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    bit          quiet;
    bit          idle_after;
    bit          saw;
    bit          wren;
    bit          sgn;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] m_rd;
    bit          m_err;
    int          m_lat;

    for (int i = 0; i < 32768; i++) mem_m[i] = 8'h00;

    i_reset = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_req_size = '0; i_req_wren = 1'b0; i_req_signed = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset ready", 32'(o_req_ready), 32'd1);
    check("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset rdata", o_rsp_rdata, 32'd0);
    check("reset err", 32'(o_rsp_err), 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // Zero the regions the test uses (RAM content is undefined at power-up).
    for (int a = 0; a <= 32'h13C; a += 4)
      do_req(1'b1, 1'b0, 2'd2, 32'(a), 32'd0, rd, err, lat, quiet, idle_after);
    for (int a = 32'h7FF0; a <= 32'h7FFC; a += 4)
      do_req(1'b1, 1'b0, 2'd2, 32'(a), 32'd0, rd, err, lat, quiet, idle_after);

    // name, wren, sgn, size, addr, wdata, exp_rd, exp_err, exp_lat
    vecs.push_back(mk("sw_aligned",   1, 0, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2));
    vecs.push_back(mk("lw_aligned",   0, 0, 2'd2, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2));
    vecs.push_back(mk("lw_size3",     0, 1, 2'd3, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2));
    vecs.push_back(mk("sb_103",       1, 0, 2'd0, 32'h103,  32'h80,       32'h0,        0, 2));
    vecs.push_back(mk("lw_100",       0, 0, 2'd2, 32'h100,  32'h0,        32'h80000000, 0, 2));
    vecs.push_back(mk("lb_103",       0, 1, 2'd0, 32'h103,  32'h0,        32'hFFFFFF80, 0, 2));
    vecs.push_back(mk("lbu_103",      0, 0, 2'd0, 32'h103,  32'h0,        32'h00000080, 0, 2));
    vecs.push_back(mk("sw_split6",    1, 0, 2'd2, 32'h6,    32'hAABBCCDD, 32'h0,        0, 3));
    vecs.push_back(mk("lw_4",         0, 0, 2'd2, 32'h4,    32'h0,        32'hCCDD0000, 0, 2));
    vecs.push_back(mk("lw_8",         0, 0, 2'd2, 32'h8,    32'h0,        32'h0000AABB, 0, 2));
    vecs.push_back(mk("lw_split6",    0, 0, 2'd2, 32'h6,    32'h0,        32'hAABBCCDD, 0, 3));
    vecs.push_back(mk("sh_split7",    1, 0, 2'd1, 32'h7,    32'h1234,     32'h0,        0, 3));
    vecs.push_back(mk("lh_split7",    0, 1, 2'd1, 32'h7,    32'h0,        32'h00001234, 0, 3));
    vecs.push_back(mk("sh_off1",      1, 0, 2'd1, 32'h5,    32'h9876,     32'h0,        0, 2));
    vecs.push_back(mk("lh_off1",      0, 1, 2'd1, 32'h5,    32'h0,        32'hFFFF9876, 0, 2));
    vecs.push_back(mk("lhu_off1",     0, 0, 2'd1, 32'h5,    32'h0,        32'h00009876, 0, 2));
    vecs.push_back(mk("lb_9",         0, 1, 2'd0, 32'h9,    32'h0,        32'hFFFFFFAA, 0, 2));
    vecs.push_back(mk("sb_hi_ignored",1, 0, 2'd0, 32'h120,  32'hFFFFFF5A, 32'h0,        0, 2));
    vecs.push_back(mk("lw_120",       0, 0, 2'd2, 32'h120,  32'h0,        32'h0000005A, 0, 2));
    vecs.push_back(mk("lw_range",     0, 0, 2'd2, 32'h8000, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk("sw_cross_lim", 1, 0, 2'd2, 32'h7FFE, 32'h55667788, 32'h0,        1, 1));
    vecs.push_back(mk("lw_7ffc",      0, 0, 2'd2, 32'h7FFC, 32'h0,        32'h0,        0, 2));
    vecs.push_back(mk("lh_7fff_err",  0, 0, 2'd1, 32'h7FFF, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk("lb_7fff_ok",   0, 1, 2'd0, 32'h7FFF, 32'h0,        32'h0,        0, 2));
    vecs.push_back(mk("lw_wrap_err",  0, 0, 2'd2, 32'hFFFFFFFE, 32'h0,    32'h0,        1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      run_and_check(vecs[i].name, vecs[i].wren, vecs[i].sgn, vecs[i].size,
                    vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                    vecs[i].exp_err, vecs[i].exp_lat);
      if (!vecs[i].exp_err && vecs[i].wren)
        model_op(vecs[i].wren, vecs[i].sgn, vecs[i].size, vecs[i].addr,
                 vecs[i].wdata, m_rd, m_err, m_lat);
    end

    // Reset during BEAT1 of a split store: beat0 bytes stay, beat1 never lands.
    i_req_valid = 1'b1; i_req_wren = 1'b1; i_req_signed = 1'b0;
    i_req_size = 2'd2; i_req_addr = 32'h22; i_req_wdata = 32'h11223344;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    check("msplit beat0 ready", 32'(o_req_ready), 32'd0);
    @(posedge i_clk); #1;
    check("msplit beat1 rsp_valid", 32'(o_rsp_valid), 32'd0);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    check("msplit ready after reset", 32'(o_req_ready), 32'd1);
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (o_rsp_valid) saw = 1'b1;
      @(posedge i_clk); #1;
    end
    check("msplit no response", 32'(saw), 32'd0);
    mem_m[32'h22] = 8'h44;
    mem_m[32'h23] = 8'h33;
    run_and_check("msplit lw_20", 1'b0, 1'b0, 2'd2, 32'h20, 32'h0, 32'h33440000, 1'b0, 2);
    run_and_check("msplit lw_24", 1'b0, 1'b0, 2'd2, 32'h24, 32'h0, 32'h00000000, 1'b0, 2);

    // Random traffic against the byte-array model.
    for (int i = 0; i < 300; i++) begin
      wren  = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      if ($urandom_range(0, 9) < 7) addr = $urandom_range(0, 32'h13C);
      else                          addr = $urandom_range(32'h7FF0, 32'h8003);
      model_op(wren, sgn, size, addr, wdata, m_rd, m_err, m_lat);
      run_and_check($sformatf("rnd%0d %s sz%0d @%h", i, wren ? "st" : "ld", size, addr),
                    wren, sgn, size, addr, wdata, m_rd, m_err, m_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
